backing_ram: RTL and testbench

BACKING_RAM -- requirements
Module: backing_ram

---
 rtl/backing_ram_pkg.sv | 11 +
 rtl/backing_ram_wbuf.sv | 53 +++++
 rtl/backing_ram.sv | 73 +++++++
 tb/tb_backing_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/backing_ram_pkg.sv
// backing_ram_pkg: default geometry and write-buffer entry layout shared by backing_ram and the cache bench.
package backing_ram_pkg;
   localparam int DEF_DATA_WIDTH = 10;
   localparam int DEF_ADDR_WIDTH = 14;
   localparam int DEF_WBUF_DEPTH = 4;
   localparam int DEF_STAT_WIDTH = 16;
   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } wbuf_entry_t;
endpackage

// File: rtl/backing_ram_wbuf.sv
// backing_ram_wbuf: posted-write FIFO with occupancy count and newest-match forwarding lookup.
module backing_ram_wbuf import backing_ram_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DEPTH      = DEF_WBUF_DEPTH,
   localparam int PW        = $clog2(DEPTH),
   localparam int CW        = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic [ADDR_WIDTH-1:0] look_addr,
   output logic [CW-1:0]         count,
   output logic [ADDR_WIDTH-1:0] head_addr,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  hit,
   output logic [DATA_WIDTH-1:0] hit_data
);
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;
   entry_t fifo [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop && count != CW'(DEPTH)) count <= count + 1'b1;
         else if (pop && !push && count != '0) count <= count - 1'b1;
      end
   always_ff @(posedge clk)
      if (push) fifo[wr_ptr] <= '{push_addr, push_data};
   assign head_addr = fifo[rd_ptr].addr;
   assign head_data = fifo[rd_ptr].data;
   // Walk oldest to newest so a later match overrides an earlier one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (CW'(i) < count && fifo[rd_ptr + PW'(i)].addr == look_addr) begin
            hit      = 1'b1;
            hit_data = fifo[rd_ptr + PW'(i)].data;
         end
   end
endmodule

// File: rtl/backing_ram.sv
// backing_ram: single-ported array fronted by a posted-write buffer with read forwarding.
// Statistics counters exist only when BACKING_RAM_STATS_EN is defined.
module backing_ram import backing_ram_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
   parameter int STAT_WIDTH = DEF_STAT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_WIDTH-1:0]         ram_addr,
   input  logic                          ram_read,
   input  logic                          ram_write,
   input  logic [DATA_WIDTH-1:0]         ram_data_in,
   output logic [DATA_WIDTH-1:0]         ram_data_out,
   output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
   output logic                          fwd_hit,
   output logic                          collision,
   output logic [STAT_WIDTH-1:0]         rd_cnt,
   output logic [STAT_WIDTH-1:0]         wr_cnt,
   output logic [STAT_WIDTH-1:0]         fwd_cnt
);
   localparam int CW = $clog2(WBUF_DEPTH) + 1;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic                  push, pop, full, hit;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_data, hit_data;
   assign full = wbuf_count == CW'(WBUF_DEPTH);
   assign push = ram_write && !ram_read;
   // Reads own the array port; a full buffer makes room for an incoming write.
   assign pop  = !ram_read && (ram_write ? full : wbuf_count != '0);
   assign fwd_hit      = !rst && ram_read && hit;
   assign ram_data_out = (!rst && ram_read) ? (hit ? hit_data : mem[ram_addr]) : '0;
   backing_ram_wbuf #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (WBUF_DEPTH)
   ) u_wbuf (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_addr(ram_addr),
      .push_data(ram_data_in),
      .look_addr(ram_addr),
      .count    (wbuf_count),
      .head_addr(head_addr),
      .head_data(head_data),
      .hit      (hit),
      .hit_data (hit_data)
   );
   always_ff @(posedge clk)
      if (pop) mem[head_addr] <= head_data;
   always_ff @(posedge clk or posedge rst)
      if (rst) collision <= 1'b0;
      else if (ram_read && ram_write) collision <= 1'b1;
`ifdef BACKING_RAM_STATS_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         fwd_cnt <= '0;
      end else begin
         if (ram_read) rd_cnt <= rd_cnt + 1'b1;
         if (push) wr_cnt <= wr_cnt + 1'b1;
         if (fwd_hit) fwd_cnt <= fwd_cnt + 1'b1;
      end
`else
   assign rd_cnt  = '0;
   assign wr_cnt  = '0;
   assign fwd_cnt = '0;
`endif
endmodule

// File: tb/tb_backing_ram.sv
// tb_backing_ram: scoreboard bench for backing_ram; reads queue expected data at drive time and compare at output.
module tb_backing_ram;
   import backing_ram_pkg::*;
`ifdef BACKING_RAM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int D = DEF_WBUF_DEPTH;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] ram_addr = '0;
   logic        ram_read = 1'b0;
   logic        ram_write = 1'b0;
   logic [9:0]  ram_data_in = '0;
   logic [9:0]  ram_data_out;
   logic [2:0]  wbuf_count;
   logic        fwd_hit, collision;
   logic [15:0] rd_cnt, wr_cnt, fwd_cnt;

   backing_ram dut (
      .clk         (clk),
      .rst         (rst),
      .ram_addr    (ram_addr),
      .ram_read    (ram_read),
      .ram_write   (ram_write),
      .ram_data_in (ram_data_in),
      .ram_data_out(ram_data_out),
      .wbuf_count  (wbuf_count),
      .fwd_hit     (fwd_hit),
      .collision   (collision),
      .rd_cnt      (rd_cnt),
      .wr_cnt      (wr_cnt),
      .fwd_cnt     (fwd_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] d;
      logic       h;
   } exp_t;
   exp_t        sb[$];
   wbuf_entry_t mq[$];
   logic [9:0]  mem_m [logic [13:0]];
   logic        m_col = 1'b0;
   logic [15:0] m_rd = '0, m_wr = '0, m_fwd = '0;
   int          n_cmp = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_col = 1'b0;
      m_rd  = '0;
      m_wr  = '0;
      m_fwd = '0;
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_rd_cnt"}, 32'(rd_cnt), STATS ? 32'(m_rd) : 32'd0);
      check({tag, "_wr_cnt"}, 32'(wr_cnt), STATS ? 32'(m_wr) : 32'd0);
      check({tag, "_fwd_cnt"}, 32'(fwd_cnt), STATS ? 32'(m_fwd) : 32'd0);
   endtask

   // One bus cycle: inputs driven #1 after posedge, outputs sampled at negedge.
   task automatic op(input logic rd, input logic wr, input logic [13:0] a, input logic [9:0] d);
      exp_t        x;
      wbuf_entry_t e;
      logic        h;
      logic [9:0]  v;
      ram_read    = rd;
      ram_write   = wr;
      ram_addr    = a;
      ram_data_in = d;
      h = 1'b0;
      v = mem_m.exists(a) ? mem_m[a] : 10'h0;
      foreach (mq[i])
         if (mq[i].addr == a) begin
            h = 1'b1;
            v = mq[i].data;
         end
      if (rd) sb.push_back('{v, h});
      @(negedge clk);
      if (rd) begin
         x = sb.pop_front();
         check("rd_data", 32'(ram_data_out), 32'(x.d));
         check("fwd_hit", 32'(fwd_hit), 32'(x.h));
      end else begin
         check("idle_data", 32'(ram_data_out), 32'd0);
         check("idle_fwd", 32'(fwd_hit), 32'd0);
      end
      if (rd && wr) m_col = 1'b1;
      else if (wr) begin
         if (mq.size() == D) begin
            e = mq.pop_front();
            mem_m[e.addr] = e.data;
         end
         mq.push_back('{a, d});
         m_wr++;
      end else if (!rd && mq.size() > 0) begin
         e = mq.pop_front();
         mem_m[e.addr] = e.data;
      end
      if (rd) m_rd++;
      if (rd && h) m_fwd++;
      @(posedge clk);
      #1;
      check("wbuf_count", 32'(wbuf_count), 32'(mq.size()));
      check("collision", 32'(collision), 32'(m_col));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(1'b0, 1'b0, 14'h0, 10'h0);
   endtask

   initial begin
      ram_read = 1'b1;
      ram_addr = 14'h40;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", 32'(ram_data_out), 32'd0);
      check("rst_fwd", 32'(fwd_hit), 32'd0);
      check("rst_count", 32'(wbuf_count), 32'd0);
      check("rst_collision", 32'(collision), 32'd0);
      check_stats("rst");
      ram_read = 1'b0;
      rst = 1'b0;

      op(1'b0, 1'b1, 14'h40, 10'h2A);
      op(1'b1, 1'b0, 14'h40, 10'h0);
      idle(1);
      op(1'b1, 1'b0, 14'h40, 10'h0);

      for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 14'(i), 10'h100 + 10'(i));
      check("force_drain_a0", 32'(mem_m.exists(14'h0) ? 1 : 0), 32'd1);
      idle(4);
      check("drained_count", 32'(wbuf_count), 32'd0);
      for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 14'(i), 10'h0);
      for (int i = 5; i < 8; i++) op(1'b0, 1'b1, 14'(i), 10'h50 + 10'(i));
      idle(3);

      op(1'b0, 1'b1, 14'h10, 10'h111);
      op(1'b0, 1'b1, 14'h10, 10'h222);
      op(1'b1, 1'b0, 14'h10, 10'h0);
      idle(2);

      op(1'b1, 1'b1, 14'h5, 10'h3FF);
      idle(2);
      op(1'b1, 1'b0, 14'h5, 10'h0);
      check_stats("mid");

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         op(r < 3 || r == 6, r >= 3 && r <= 6, 14'($urandom_range(0, 7)), 10'($urandom));
      end
      check_stats("rand");

      op(1'b0, 1'b1, 14'h1, 10'h1AA);
      op(1'b0, 1'b1, 14'h2, 10'h1BB);
      ram_read  = 1'b1;
      ram_write = 1'b0;
      ram_addr  = 14'h2;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst_data", 32'(ram_data_out), 32'd0);
      check("midrst_fwd", 32'(fwd_hit), 32'd0);
      check("midrst_count", 32'(wbuf_count), 32'd0);
      check("midrst_collision", 32'(collision), 32'd0);
      check_stats("midrst");
      ram_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      op(1'b0, 1'b1, 14'h20, 10'h020);
      op(1'b0, 1'b1, 14'h21, 10'h021);
      op(1'b0, 1'b1, 14'h22, 10'h022);
      op(1'b1, 1'b0, 14'h22, 10'h0);
      op(1'b1, 1'b0, 14'h40, 10'h0);
      check("stats_rd", 32'(rd_cnt), STATS ? 32'd2 : 32'd0);
      check("stats_wr", 32'(wr_cnt), STATS ? 32'd3 : 32'd0);
      check("stats_fwd", 32'(fwd_cnt), STATS ? 32'd1 : 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
